// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one input bit per clock.
// Start/busy/done handshake; bcd/sign/overflow change only when done pulses.
module bcd_converter_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  overflow
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (BW < WIDTH) begin : g_cfg_check
        $error("bcd_converter_seq: 4*DIGITS must be >= WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            work_q;
    logic [WIDTH-1:0]         mag_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     sgn_q;
    logic                     ovf_q;

    logic                     accept;
    logic                     step;
    logic                     finish;
    logic                     neg_in;
    logic signed [WIDTH-1:0]  bin_s;
    logic [WIDTH-1:0]         mag_in;
    logic [BW-1:0]            work_adj;

    // Digits >= 5 get +3 so that the following left shift carries correctly into the next digit.
    function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] d);
        logic [BW-1:0] r;
        r = d;
        for (int k = 0; k < DIGITS; k++) begin
            if (d[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = d[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic neg);
        logic signed [WIDTH-1:0] n;
        n = -v;
        return neg ? $unsigned(n) : $unsigned(v);
    endfunction

    assign bin_s    = $signed(bin);
    assign neg_in   = (SIGNED != 0) && bin[WIDTH-1];
    assign mag_in   = magnitude(bin_s, neg_in);
    assign work_adj = add3_digits(work_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; result registers move only on finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            mag_q    <= '0;
            cnt_q    <= '0;
            sgn_q    <= 1'b0;
            ovf_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            sign     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                mag_q  <= mag_in;
                sgn_q  <= neg_in;
                work_q <= '0;
                ovf_q  <= 1'b0;
                cnt_q  <= CNT_W'(WIDTH);
                busy   <= 1'b1;
            end
            if (step) begin
                work_q <= {work_adj[BW-2:0], mag_q[WIDTH-1]};
                mag_q  <= {mag_q[WIDTH-2:0], 1'b0};
                ovf_q  <= ovf_q | work_adj[BW-1];
                cnt_q  <= cnt_q - CNT_W'(1);
            end
            if (finish) begin
                bcd      <= work_q;
                sign     <= sgn_q;
                overflow <= ovf_q;
                busy     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Scoreboard bench: two converters (16-bit unsigned/5 digits, 16-bit signed/4 digits) share stimulus;
// expected results come from a decimal-arithmetic model and are checked when done pulses.
module tb_bcd_converter_seq;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  bin;

    logic          busy_a, done_a, sign_a, ovf_a;
    logic [19:0]   bcd_a;
    logic          busy_b, done_b, sign_b, ovf_b;
    logic [15:0]   bcd_b;

    typedef struct {
        logic [19:0] bcd;
        logic        sign;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t  qa[$];
    exp_t  qb[$];
    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;
    logic [21:0] held_a;
    logic [17:0] held_b;

    bcd_converter_seq #(.WIDTH(W), .DIGITS(5), .SIGNED(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .sign(sign_a), .overflow(ovf_a)
    );

    bcd_converter_seq #(.WIDTH(W), .DIGITS(4), .SIGNED(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .sign(sign_b), .overflow(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: magnitude from the numeric value, digits by repeated division by ten.
    function automatic exp_t model(input logic [W-1:0] v, input int digits, input bit sgn,
                                   input int acc);
        exp_t   e;
        longint m, p, lim;
        bit     neg;
        neg = sgn && v[W-1];
        m   = neg ? (longint'(65536) - longint'(v)) : longint'(v);
        e.bcd = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            if (k < digits) e.bcd[4*k +: 4] = 4'((m / p) % 10);
            p = p * 10;
        end
        lim = 1;
        for (int k = 0; k < digits; k++) lim = lim * 10;
        e.ovf  = (m >= lim);
        e.sign = neg;
        e.acc  = acc;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_a = '0;
            held_b = '0;
        end else begin
            if (done_a) begin
                if (qa.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_done_a: done=1 with nothing pending, expected 0");
                end else begin
                    e = qa.pop_front();
                    check("bcd_a", 32'(bcd_a), 32'(e.bcd));
                    check("sign_a", 32'(sign_a), 32'(e.sign));
                    check("ovf_a", 32'(ovf_a), 32'(e.ovf));
                    check("latency_a", 32'(cyc - e.acc), 32'(W + 1));
                end
                held_a = {sign_a, ovf_a, bcd_a};
            end else begin
                check("hold_a", 32'({sign_a, ovf_a, bcd_a}), 32'(held_a));
            end
            if (done_b) begin
                if (qb.size() == 0) begin
                    checks++;
                    $display("FAIL spurious_done_b: done=1 with nothing pending, expected 0");
                end else begin
                    e = qb.pop_front();
                    check("bcd_b", 32'(bcd_b), 32'(e.bcd));
                    check("sign_b", 32'(sign_b), 32'(e.sign));
                    check("ovf_b", 32'(ovf_b), 32'(e.ovf));
                    check("latency_b", 32'(cyc - e.acc), 32'(W + 1));
                end
                held_b = {sign_b, ovf_b, bcd_b};
            end else begin
                check("hold_b", 32'({sign_b, ovf_b, bcd_b}), 32'(held_b));
            end
        end
    end

    // Called at a negedge while both converters are idle (or in their done cycle).
    task automatic convert(input logic [W-1:0] v);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        qa.push_back(model(v, 5, 1'b0, cyc));
        qb.push_back(model(v, 4, 1'b1, cyc));
        start = 1'b0;
        bin   = W'($urandom);
        check("busy_a_after_accept", 32'(busy_a), 32'd1);
        check("busy_b_after_accept", 32'(busy_b), 32'd1);
    endtask

    task automatic wait_done(input bit noise);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done_a) begin
                seen  = 1'b1;
                start = 1'b0;
            end else if (noise && $urandom_range(0, 5) == 0) begin
                start = 1'b1;
                bin   = W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (seen) passed++;
        else begin
            $display("FAIL done_timeout: no done within 40 cycles, expected done");
            qa.delete();
            qb.delete();
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_done_a", 32'(done_a), 32'd0);
        check("rst_bcd_a", 32'(bcd_a), 32'd0);
        check("rst_sign_a", 32'(sign_a), 32'd0);
        check("rst_ovf_a", 32'(ovf_a), 32'd0);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        check("rst_bcd_b", 32'(bcd_b), 32'd0);
        check("rst_sign_b", 32'(sign_b), 32'd0);
        check("rst_ovf_b", 32'(ovf_b), 32'd0);
    endtask

    logic [W-1:0] dir_vals[11];
    logic [W-1:0] specials[6];

    initial begin
        logic [W-1:0] v;
        dir_vals = '{16'd255, 16'd0, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd65535,
                     16'h8000, 16'd12345, 16'd9999};
        specials = '{16'd0, 16'h8000, 16'hFFFF, 16'd9999, 16'd10000, 16'h7FFF};
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();
        #1 rst_n = 1'b1;
        @(negedge clk);

        foreach (dir_vals[i]) begin
            convert(dir_vals[i]);
            wait_done(1'b0);
            @(negedge clk);
        end

        // Start pulsed mid-conversion must be ignored.
        convert(16'd500);
        @(negedge clk);
        start = 1'b1;
        bin   = 16'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0);
        repeat (W + 4) @(negedge clk);

        // Reset in the middle of a conversion.
        convert(16'd4321);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        qa.delete();
        qb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (W + 6) @(negedge clk);
        convert(16'd42);
        wait_done(1'b0);

        for (int n = 0; n < 3000; n++) begin
            v = W'($urandom);
            if ($urandom_range(0, 7) == 0) v = specials[$urandom_range(0, 5)];
            convert(v);
            wait_done(1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("pending_a", 32'(qa.size()), 32'd0);
        check("pending_b", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
